// File: rtl/processor_pkg.sv
// Constants and helpers shared by the fetch stage and the control unit.
// The opcode is the top op_code_width bits of every instruction word.
package processor_pkg;

    localparam int op_code_width = 5;

    localparam logic [op_code_width-1:0] OP_IADD = 5'b01100;
    localparam logic [op_code_width-1:0] OP_LDM  = 5'b10011;
    localparam logic [op_code_width-1:0] OP_LDD  = 5'b10100;
    localparam logic [op_code_width-1:0] OP_STD  = 5'b10101;

    // These opcodes are followed by a 16-bit immediate word in memory.
    function automatic logic has_imm(input logic [op_code_width-1:0] opcode);
        logic result;
        result = 1'b0;
        case (opcode)
            OP_IADD, OP_LDM, OP_LDD, OP_STD: result = 1'b1;
            default:                         result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/if_id_register.sv
// Pipeline register bank with enable and clear, used between fetch and decode.
// Clear drops only the valid bit; the payload is don't-care while invalid.
module if_id_register #(
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data_d,
    input  logic             valid_d,
    output logic [WIDTH-1:0] data_q,
    output logic             valid_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (en) begin
            if (clr) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
                if (load) begin
                    data_q <= data_d;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with reset-vector load, two-word instruction assembly
// and the IF/ID pipeline register feeding decode.
module fetch_stage
    import processor_pkg::*;
#(
    parameter int Num_of_bits   = 16,
    parameter int pc_width      = 32,
    parameter int op_code_width = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [pc_width-1:0]    redirect_target,
    output logic [pc_width-1:0]    imem_addr,
    input  logic [Num_of_bits-1:0] imem_data,
    output logic [Num_of_bits-1:0] if_id_instruction,
    output logic [Num_of_bits-1:0] if_id_immediate,
    output logic [pc_width-1:0]    if_id_pc,
    output logic [pc_width-1:0]    if_id_pc_next,
    output logic                   if_id_valid,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        VEC_LO    = 2'd0,
        VEC_HI    = 2'd1,
        FETCH     = 2'd2,
        FETCH_IMM = 2'd3
    } fetch_state_t;

    localparam int IF_ID_W = 2 * Num_of_bits + 2 * pc_width;

    fetch_state_t            state, state_n;
    logic [pc_width-1:0]     pc, pc_n, pc_inc;
    logic [Num_of_bits-1:0]  vec_lo, vec_lo_n;
    logic [Num_of_bits-1:0]  hold_instr, hold_instr_n;
    logic [pc_width-1:0]     hold_pc, hold_pc_n;
    logic                    fetching;
    logic                    if_en, if_clr, if_load, if_valid_d;
    logic [IF_ID_W-1:0]      if_data_d, if_data_q;

    // Control from later stages: redirect wins over stall; stall freezes every
    // register of this stage; both are ignored while the reset vector loads.
    assign fetching  = (state == FETCH) || (state == FETCH_IMM);
    assign if_en     = fetching && (!stall || redirect);
    assign if_clr    = fetching && redirect;
    assign pc_inc    = pc + 1'b1;
    assign imem_addr = pc;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= VEC_LO;
            pc         <= '0;
            vec_lo     <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            vec_lo     <= vec_lo_n;
            hold_instr <= hold_instr_n;
            hold_pc    <= hold_pc_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        vec_lo_n     = vec_lo;
        hold_instr_n = hold_instr;
        hold_pc_n    = hold_pc;
        if_load      = 1'b0;
        if_valid_d   = 1'b0;
        if_data_d    = '0;
        case (state)
            VEC_LO: begin
                vec_lo_n = imem_data;
                pc_n     = pc_width'(1);
                state_n  = VEC_HI;
            end
            VEC_HI: begin
                pc_n    = pc_width'({imem_data, vec_lo});
                state_n = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    pc_n    = redirect_target;
                    state_n = FETCH;
                end else if (!stall) begin
                    pc_n = pc_inc;
                    if (has_imm(imem_data[Num_of_bits-1 -: op_code_width])) begin
                        hold_instr_n = imem_data;
                        hold_pc_n    = pc;
                        state_n      = FETCH_IMM;
                    end else begin
                        if_load    = 1'b1;
                        if_valid_d = 1'b1;
                        if_data_d  = {imem_data, {Num_of_bits{1'b0}}, pc, pc_inc};
                    end
                end
            end
            FETCH_IMM: begin
                if (redirect) begin
                    pc_n    = redirect_target;
                    state_n = FETCH;
                end else if (!stall) begin
                    pc_n       = pc_inc;
                    state_n    = FETCH;
                    if_load    = 1'b1;
                    if_valid_d = 1'b1;
                    if_data_d  = {hold_instr, imem_data, hold_pc, pc_inc};
                end
            end
            default: begin
                state_n = VEC_LO;
            end
        endcase
    end

    if_id_register #(
        .WIDTH(IF_ID_W)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .en      (if_en),
        .clr     (if_clr),
        .load    (if_load),
        .data_d  (if_data_d),
        .valid_d (if_valid_d),
        .data_q  (if_data_q),
        .valid_q (if_id_valid)
    );

    assign {if_id_instruction, if_id_immediate, if_id_pc, if_id_pc_next} = if_data_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset vector, one/two-word streams, stall,
// redirect over stall, asynchronous reset mid-instruction and PC wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_id_instruction;
    logic [15:0] if_id_immediate;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_next;
    logic        if_id_valid;
    logic [1:0]  state_dbg;

    logic [15:0] mem [0:255];
    int          checks = 0;
    int          errors = 0;

    localparam logic [1:0] S_VEC_LO    = 2'd0;
    localparam logic [1:0] S_VEC_HI    = 2'd1;
    localparam logic [1:0] S_FETCH     = 2'd2;
    localparam logic [1:0] S_FETCH_IMM = 2'd3;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:0]];

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_target   (redirect_target),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .if_id_instruction (if_id_instruction),
        .if_id_immediate   (if_id_immediate),
        .if_id_pc          (if_id_pc),
        .if_id_pc_next     (if_id_pc_next),
        .if_id_valid       (if_id_valid),
        .state_dbg         (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [15:0] ins, input logic [15:0] imm,
                              input logic [31:0] pc, input logic [31:0] pcn);
        check({tag, ".valid"}, {31'd0, if_id_valid}, 32'd1);
        check({tag, ".instr"}, {16'd0, if_id_instruction}, {16'd0, ins});
        check({tag, ".imm"},   {16'd0, if_id_immediate}, {16'd0, imm});
        check({tag, ".pc"},    if_id_pc, pc);
        check({tag, ".pcnext"}, if_id_pc_next, pcn);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".addr"},   imem_addr, 32'd0);
        check({tag, ".state"},  {30'd0, state_dbg}, {30'd0, S_VEC_LO});
        check({tag, ".valid"},  {31'd0, if_id_valid}, 32'd0);
        check({tag, ".instr"},  {16'd0, if_id_instruction}, 32'd0);
        check({tag, ".imm"},    {16'd0, if_id_immediate}, 32'd0);
        check({tag, ".pc"},     if_id_pc, 32'd0);
        check({tag, ".pcnext"}, if_id_pc_next, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'd0;

        // Reset vector 0x20 and a one-word NOT stream
        mem[0] = 16'h0020; mem[1] = 16'h0000;
        mem[8'h20] = 16'h1800; mem[8'h21] = 16'h1801;
        #1;
        check_zero("rst0");
        #1 reset = 1'b0;
        step(); check("v.addr1", imem_addr, 32'h1);
        check("v.valid1", {31'd0, if_id_valid}, 32'd0);
        step(); check("v.addr2", imem_addr, 32'h20);
        check("v.valid2", {31'd0, if_id_valid}, 32'd0);
        step(); check_ifid("not1", 16'h1800, 16'h0, 32'h20, 32'h21);
        check("not1.addr", imem_addr, 32'h21);
        step(); check_ifid("not2", 16'h1801, 16'h0, 32'h21, 32'h22);

        // LDM at 0x20, NOT, LDD stalled 3 cycles in FETCH_IMM, NOT, then redirect over stall
        reset = 1'b1; #1;
        check_zero("rst1");
        mem[8'h20] = 16'h9800; mem[8'h21] = 16'h1234;
        mem[8'h22] = 16'h1800;
        mem[8'h23] = 16'hA000; mem[8'h24] = 16'h5555;
        mem[8'h25] = 16'h1802;
        mem[8'h26] = 16'h9800; mem[8'h27] = 16'h4321;
        mem[8'h40] = 16'h1840; mem[8'h41] = 16'h9800; mem[8'h42] = 16'h7777;
        step(); reset = 1'b0;
        step(); step(); step();
        check("ldm.bubble", {31'd0, if_id_valid}, 32'd0);
        check("ldm.state", {30'd0, state_dbg}, {30'd0, S_FETCH_IMM});
        check("ldm.addr", imem_addr, 32'h21);
        step(); check_ifid("ldm", 16'h9800, 16'h1234, 32'h20, 32'h22);
        step(); check_ifid("not3", 16'h1800, 16'h0, 32'h22, 32'h23);
        step();
        check("ldd.bubble", {31'd0, if_id_valid}, 32'd0);
        check("ldd.addr", imem_addr, 32'h24);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.addr", imem_addr, 32'h24);
            check("stall.state", {30'd0, state_dbg}, {30'd0, S_FETCH_IMM});
            check("stall.valid", {31'd0, if_id_valid}, 32'd0);
            check("stall.instr", {16'd0, if_id_instruction}, 32'h1800);
            check("stall.pc", if_id_pc, 32'h22);
            check("stall.pcnext", if_id_pc_next, 32'h23);
        end
        stall = 1'b0;
        step(); check_ifid("ldd", 16'hA000, 16'h5555, 32'h23, 32'h25);
        step(); check_ifid("not4", 16'h1802, 16'h0, 32'h25, 32'h26);
        step();
        check("ldm2.state", {30'd0, state_dbg}, {30'd0, S_FETCH_IMM});
        redirect = 1'b1; stall = 1'b1; redirect_target = 32'h40;
        step();
        check("redir.addr", imem_addr, 32'h40);
        check("redir.valid", {31'd0, if_id_valid}, 32'd0);
        check("redir.state", {30'd0, state_dbg}, {30'd0, S_FETCH});
        redirect = 1'b0; stall = 1'b0;
        step(); check_ifid("target", 16'h1840, 16'h0, 32'h40, 32'h41);
        step();
        check("ldm3.state", {30'd0, state_dbg}, {30'd0, S_FETCH_IMM});
        check("ldm3.addr", imem_addr, 32'h42);

        // Asynchronous reset between edges, mid-FETCH_IMM
        #3 reset = 1'b1;
        #1 check_zero("rst_mid");

        // PC wrap from vector 0xFFFFFFFF; redirect/stall ignored in vector states
        mem[0] = 16'hFFFF; mem[1] = 16'hFFFF; mem[8'hFF] = 16'h1803;
        step(); reset = 1'b0;
        redirect = 1'b1; stall = 1'b1; redirect_target = 32'h40;
        step(); check("wrap.addr1", imem_addr, 32'h1);
        step(); check("wrap.addr2", imem_addr, 32'hFFFF_FFFF);
        check("wrap.valid2", {31'd0, if_id_valid}, 32'd0);
        redirect = 1'b0; stall = 1'b0;
        step(); check_ifid("wrap", 16'h1803, 16'h0, 32'hFFFF_FFFF, 32'h0);
        check("wrap.addr3", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage processor; sits directly upstream of the control unit and decode stage. It owns the PC, loads it from the reset vector held in instruction memory words 0 and 1, and assembles one- or two-word instructions (16-bit instruction plus a 16-bit immediate word). It then presents them to decode with a valid flag, honouring stall and redirect requests from later stages.

## Interface
- `Num_of_bits`, 16, instruction and immediate word width
- `pc_width`, 32, PC and instruction-memory address width
- `op_code_width`, 5, opcode field width, located in `instruction[Num_of_bits-1 -: op_code_width]`
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `stall`  in  1  hazard unit: hold PC, state and IF/ID contents
- `redirect`  in  1  taken jump/call/ret/rti from a later stage: flush and refetch
- `redirect_target`  in  `pc_width`  new PC when `redirect`=1
- `imem_addr`  out  `pc_width`  instruction-memory address, combinational copy of `pc`
- `imem_data`  in  `Num_of_bits`  instruction-memory read data, combinational from `imem_addr`
- `if_id_instruction`  out  `Num_of_bits`  registered instruction word
- `if_id_immediate`  out  `Num_of_bits`  registered immediate; 0 for one-word instructions
- `if_id_pc`  out  `pc_width`  address of the instruction's first word
- `if_id_pc_next`  out  `pc_width`  address following the whole instruction (call return address)
- `if_id_valid`  out  1  IF/ID holds a real instruction; 0 means bubble

## Operation
- States: `VEC_LO`, `VEC_HI`, `FETCH`, `FETCH_IMM`.
- `VEC_LO`: read word 0 into `vec_lo`; `pc` <= 1; go to `VEC_HI`.
- `VEC_HI`: `pc` <= {`imem_data`, `vec_lo`} (word 1 is the high half); go to `FETCH`.
- In both vector states, `stall` and `redirect` are ignored and `if_id_valid`=0.
- `FETCH`: read word at `pc`. If `has_imm(opcode)`:
  - `hold_instr` <= word; `hold_pc` <= `pc`; `pc` <= `pc`+1
  - `if_id_valid` <= 0; go to `FETCH_IMM`
- `FETCH`, otherwise:
  - IF/ID <= {word, 0, `pc`, `pc`+1}; `if_id_valid` <= 1; `pc` <= `pc`+1.
- `FETCH_IMM`:
  - IF/ID <= {`hold_instr`, `imem_data`, `hold_pc`, `pc`+1}; `if_id_valid` <= 1
  - `pc` <= `pc`+1; go to `FETCH`
- `stall`=1 in `FETCH`/`FETCH_IMM`: no register changes at all. IF/ID keeps its value, including `if_id_valid`.
- `redirect`=1 in `FETCH`/`FETCH_IMM` (priority over `stall`):
  - `pc` <= `redirect_target`; state <= `FETCH`
  - `if_id_valid` <= 0; any half-fetched `hold_instr` is discarded
- PC arithmetic is modulo 2^`pc_width`; `pc`+1 from 0xFFFFFFFF wraps to 0. No error is raised.
- `if_id_instruction`/`if_id_immediate`/`if_id_pc`/`if_id_pc_next` are don't-care to consumers when `if_id_valid`=0. They still change only as specified above.

## Timing
- Reset (asynchronous, any state, mid-instruction included):
  - `pc`=0, state=`VEC_LO`
  - all `if_id_*`=0, `hold_instr`=0, `hold_pc`=0, `vec_lo`=0
  - `imem_addr`=0
- First instruction: fetched in the 3rd rising edge after reset deassertion. `if_id_valid`=1 after that edge for a one-word instruction, or after the 4th edge for a two-word instruction.
- Throughput: one instruction per cycle for one-word instructions; one per two cycles for two-word instructions. Each two-word instruction inserts one bubble.
- Latency: the word addressed in a cycle appears on IF/ID after the next rising edge.
- Redirect: `imem_addr`=`redirect_target` in the cycle after `redirect`. The target instruction is valid on IF/ID one edge later, with exactly one bubble between.

## Structure
- Shared package `processor_pkg`: the `op_code_width` constant, and these opcode constants:
  - `OP_IADD`=5'b01100, `OP_LDM`=5'b10011, `OP_LDD`=5'b10100, `OP_STD`=5'b10101
- `processor_pkg` also holds function `has_imm(opcode)`, true for exactly those four. The control unit uses the same constants.
- State enum `fetch_state_t` is local to the block.
- Sub-module `if_id_register`: a plain enable/clear register bank, with `en` = ~`stall` | `redirect` and `clr` = `redirect`. It is used here and reused as a template for ID/EX.

## Test plan
- Reset vector: memory word 0=0x0020, word 1=0x0000, release reset.
  - `imem_addr` goes 0, 1, 0x20
  - first `if_id_pc`=0x20, valid on the 3rd edge
- One-word stream: word 0x20 holds a NOT-type opcode 5'b00011.
  - `if_id_instruction`=that word, `if_id_immediate`=0, `if_id_pc_next`=0x21
- LDM: 0x20=0x9800 (`OP_LDM`), 0x21=0x1234.
  - bubble after the 3rd edge
  - after the 4th edge: `if_id_instruction`=0x9800, `if_id_immediate`=0x1234, `if_id_pc`=0x20, `if_id_pc_next`=0x22
- Stall: assert `stall` for 3 cycles during `FETCH_IMM`. `pc` and all `if_id_*` stay frozen; completion resumes with the same values.
- Redirect vs stall: assert `redirect`=1, `stall`=1, target 0x40 during `FETCH_IMM` of an LDM.
  - next `imem_addr`=0x40; `if_id_valid`=0
  - LDM never appears on IF/ID
- Reset mid-`FETCH_IMM`, and PC wrap (vector 0xFFFFFFFF):
  - reset → outputs zero immediately, state `VEC_LO`
  - wrap case → next `imem_addr`=0
